// File: rtl/imem_loader.sv
// imem_loader: streams a program into instruction memory and holds the CPU in reset until it is loaded
// Parameters: ADDR_W word-address width, RUN_DELAY cycles of cpu_rst after the last write (1..255).
// Ports: clk, rst (sync, active-high); start begins/restarts a load;
//        in_valid/in_data/in_last upstream word stream, in_ready accept indication;
//        imem_we/imem_addr/imem_wdata memory write port; cpu_rst CPU reset; load_done CPU released;
//        word_count words accepted; err_overflow sticky memory-full flag; checksum sum of accepted words.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to build the checksum accumulator (otherwise checksum is 0).
module imem_loader #(
   parameter int ADDR_W    = 7,
   parameter int RUN_DELAY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              load_done,
   output logic [ADDR_W:0]   word_count,
   output logic              err_overflow,
   output logic [31:0]       checksum
);
   typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;
   state_t state, state_nx;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   count;
   logic [7:0]        hold;
   logic              err, accept, at_top, finish, clear;
   // rst gates acceptance so a word presented during the reset cycle is never written
   assign accept = state == LOAD && in_valid && !rst;
   assign at_top = addr == {ADDR_W{1'b1}};
   assign finish = accept && (in_last || at_top);
   assign clear  = (state == IDLE || state == RUN) && start;
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_nx;
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: state_nx = start ? LOAD : IDLE;
         LOAD: state_nx = finish ? HOLD : LOAD;
         HOLD: state_nx = hold == 8'd1 ? RUN : HOLD;
         RUN:  state_nx = start ? LOAD : RUN;
      endcase
   end
   always_comb begin
      in_ready     = state == LOAD;
      cpu_rst      = state != RUN;
      load_done    = state == RUN;
      imem_we      = accept;
      imem_addr    = addr;
      imem_wdata   = in_data;
      word_count   = count;
      err_overflow = err;
   end
   // the address saturates at the top word; count is one bit wider so a full load reads 2^ADDR_W
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         addr  <= '0;
         count <= '0;
         err   <= 1'b0;
      end else if (accept) begin
         addr  <= at_top ? addr : addr + ADDR_W'(1);
         count <= count + (ADDR_W+1)'(1);
         err   <= err | (at_top && !in_last);
      end
   end
   // the transition to RUN fires on the edge where hold steps 1 -> 0, giving RUN_DELAY cycles in HOLD
   always_ff @(posedge clk) begin
      if (rst)
         hold <= '0;
      else if (finish)
         hold <= 8'(RUN_DELAY);
      else if (state == HOLD)
         hold <= hold - 8'd1;
   end
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] sum;
   always_ff @(posedge clk) begin
      if (rst || clear)
         sum <= '0;
      else if (accept)
         sum <= sum + in_data;
   end
   assign checksum = sum;
`else
   assign checksum = '0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader (default instance plus a 4-word instance)
module tb_imem_loader;
   localparam int AW  = 7;
   localparam int SAW = 2;
   localparam int RD  = 4;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
   logic [31:0] in_data = '0;
   logic in_ready, imem_we, cpu_rst, load_done, err_overflow;
   logic [AW-1:0] imem_addr;
   logic [31:0] imem_wdata, checksum;
   logic [AW:0] word_count;
   logic s_start = 1'b0, s_in_valid = 1'b0, s_in_last = 1'b0;
   logic [31:0] s_in_data = '0;
   logic s_in_ready, s_imem_we, s_cpu_rst, s_load_done, s_err_overflow;
   logic [SAW-1:0] s_imem_addr;
   logic [31:0] s_imem_wdata, s_checksum;
   logic [SAW:0] s_word_count;
   imem_loader #(.ADDR_W(AW), .RUN_DELAY(RD)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_rst(cpu_rst), .load_done(load_done), .word_count(word_count), .err_overflow(err_overflow),
      .checksum(checksum));
   imem_loader #(.ADDR_W(SAW), .RUN_DELAY(RD)) sdut (
      .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_data(s_in_data), .in_last(s_in_last),
      .in_ready(s_in_ready), .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
      .cpu_rst(s_cpu_rst), .load_done(s_load_done), .word_count(s_word_count), .err_overflow(s_err_overflow),
      .checksum(s_checksum));
   int n_chk = 0;
   int n_fail = 0;
   // observed memory writes of the main instance, sampled mid-cycle
   int wa[$];
   logic [31:0] wd[$];
   always begin
      @(negedge clk);
      #3;
      if (imem_we) begin
         wa.push_back(int'(imem_addr));
         wd.push_back(imem_wdata);
      end
   end
   function automatic logic [31:0] sum_of(input logic [31:0] w[$]);
      logic [31:0] s = '0;
      foreach (w[i]) s += w[i];
      return CK_EN ? s : 32'd0;
   endfunction
   task automatic pulse_start;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask
   // drives one program; ends on the first cycle after the last word
   task automatic drive_load(input logic [31:0] w[$], input bit gaps, input bit poke_start);
      foreach (w[i]) begin
         if (gaps) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = $urandom;
            in_last  = 1'($urandom);
            start    = 1'b0;
         end
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = w[i];
         in_last  = i == w.size() - 1;
         start    = poke_start && i == 1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      start    = 1'b0;
   endtask
   // counts cpu_rst-high cycles from here, bounded
   task automatic count_hold(output int h);
      h = 0;
      while (cpu_rst && h < 20) begin
         h++;
         @(negedge clk);
      end
   endtask
   task automatic check_load(input string tag, input logic [31:0] w[$], input int h);
      n_chk++;
      if (wa.size() !== w.size()) begin
         n_fail++;
         $display("FAIL %s write count: got %0d, expected %0d", tag, wa.size(), w.size());
      end
      foreach (w[i]) begin
         n_chk++;
         if (i >= wa.size() || wa[i] !== i || wd[i] !== w[i]) begin
            n_fail++;
            $display("FAIL %s write %0d: got addr %0d data %h, expected addr %0d data %h", tag, i,
                     i < wa.size() ? wa[i] : -1, i < wd.size() ? wd[i] : 32'hx, i, w[i]);
         end
      end
      n_chk++;
      if (int'(word_count) !== w.size()) begin
         n_fail++;
         $display("FAIL %s word_count: got %0d, expected %0d", tag, word_count, w.size());
      end
      n_chk++;
      if (h !== RD || load_done !== 1'b1 || cpu_rst !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s hold: got %0d cycles load_done %b cpu_rst %b in_ready %b, expected %0d 1 0 0",
                  tag, h, load_done, cpu_rst, in_ready, RD);
      end
      n_chk++;
      if (checksum !== sum_of(w)) begin
         n_fail++;
         $display("FAIL %s checksum: got %h, expected %h", tag, checksum, sum_of(w));
      end
   endtask
   task automatic test_reset;
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = $urandom;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      n_chk++;
      if ({in_ready, imem_we, imem_addr, cpu_rst, load_done, word_count, err_overflow, checksum} !==
          {1'b0, 1'b0, {AW{1'b0}}, 1'b1, 1'b0, {(AW+1){1'b0}}, 1'b0, 32'd0}) begin
         n_fail++;
         $display("FAIL reset main: got rdy %b we %b addr %0d crst %b done %b wc %0d err %b ck %h, expected 0 0 0 1 0 0 0 0",
                  in_ready, imem_we, imem_addr, cpu_rst, load_done, word_count, err_overflow, checksum);
      end
      n_chk++;
      if ({s_in_ready, s_imem_we, s_imem_addr, s_cpu_rst, s_load_done, s_word_count, s_err_overflow} !==
          {1'b0, 1'b0, {SAW{1'b0}}, 1'b1, 1'b0, {(SAW+1){1'b0}}, 1'b0}) begin
         n_fail++;
         $display("FAIL reset small: got rdy %b we %b addr %0d crst %b done %b wc %0d err %b, expected 0 0 0 1 0 0 0",
                  s_in_ready, s_imem_we, s_imem_addr, s_cpu_rst, s_load_done, s_word_count, s_err_overflow);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask
   task automatic test_basic;
      logic [31:0] w[$] = '{32'h20010005, 32'h20020003, 32'h00000000};
      int h;
      wa.delete();
      wd.delete();
      pulse_start();
      drive_load(w, 1'b0, 1'b0);
      count_hold(h);
      check_load("basic", w, h);
   endtask
   task automatic test_run_restart;
      logic [31:0] w[$];
      int h;
      repeat (6) w.push_back($urandom);
      wa.delete();
      wd.delete();
      @(negedge clk);
      in_valid = 1'b1;
      in_data = $urandom;
      start = 1'b1;
      #1;
      n_chk++;
      if (imem_we !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL run idle write: got we %b rdy %b, expected 0 0", imem_we, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      start = 1'b0;
      n_chk++;
      if (cpu_rst !== 1'b1 || load_done !== 1'b0 || word_count !== '0 || imem_addr !== '0 ||
          checksum !== '0 || in_ready !== 1'b1 || wa.size() !== 0) begin
         n_fail++;
         $display("FAIL restart: got crst %b done %b wc %0d addr %0d ck %h rdy %b writes %0d, expected 1 0 0 0 0 1 0",
                  cpu_rst, load_done, word_count, imem_addr, checksum, in_ready, wa.size());
      end
      drive_load(w, 1'b0, 1'b1);
      count_hold(h);
      check_load("restart", w, h);
   endtask
   task automatic test_gaps;
      logic [31:0] w[$] = '{32'h20010005, 32'h20020003, 32'h00000000};
      int h;
      wa.delete();
      wd.delete();
      pulse_start();
      drive_load(w, 1'b1, 1'b0);
      count_hold(h);
      check_load("gaps", w, h);
   endtask
   task automatic test_checksum;
      logic [31:0] w[$] = '{32'hFFFFFFFF, 32'h00000002};
      int h;
      wa.delete();
      wd.delete();
      pulse_start();
      drive_load(w, $urandom_range(0, 1) == 1, 1'b0);
      count_hold(h);
      check_load("checksum", w, h);
      n_chk++;
      if (checksum !== (CK_EN ? 32'h1 : 32'h0)) begin
         n_fail++;
         $display("FAIL checksum wrap: got %h, expected %h", checksum, CK_EN ? 32'h1 : 32'h0);
      end
   endtask
   task automatic test_mid_reset;
      logic [31:0] w[$];
      int h;
      repeat (3) w.push_back($urandom);
      wa.delete();
      wd.delete();
      pulse_start();
      repeat (2) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data = $urandom;
      end
      @(negedge clk);
      rst = 1'b1;
      in_data = $urandom;
      #1;
      n_chk++;
      if (imem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL reset-cycle write: got we %b, expected 0", imem_we);
      end
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      n_chk++;
      if (cpu_rst !== 1'b1 || word_count !== '0 || in_ready !== 1'b0 || imem_addr !== '0 || wa.size() !== 2) begin
         n_fail++;
         $display("FAIL mid reset: got crst %b wc %0d rdy %b addr %0d writes %0d, expected 1 0 0 0 2",
                  cpu_rst, word_count, in_ready, imem_addr, wa.size());
      end
      wa.delete();
      wd.delete();
      pulse_start();
      drive_load(w, 1'b0, 1'b0);
      count_hold(h);
      check_load("reload", w, h);
   endtask
   task automatic test_overflow;
      logic [31:0] s = '0;
      int h;
      @(negedge clk);
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         s_in_valid = 1'b1;
         s_in_last = 1'b0;
         s_in_data = $urandom;
         #1;
         n_chk++;
         if (s_in_ready !== (i < 4) || s_imem_we !== (i < 4) || (i < 4 && int'(s_imem_addr) !== i)) begin
            n_fail++;
            $display("FAIL overflow word %0d: got rdy %b we %b addr %0d, expected %b %b %0d",
                     i, s_in_ready, s_imem_we, s_imem_addr, i < 4, i < 4, i);
         end
         if (i < 4) s += s_in_data;
      end
      h = 1;
      @(negedge clk);
      s_in_valid = 1'b0;
      while (s_cpu_rst && h < 20) begin
         h++;
         @(negedge clk);
      end
      n_chk++;
      if (h !== RD || s_load_done !== 1'b1 || s_err_overflow !== 1'b1 || s_word_count !== 3'd4 ||
          s_checksum !== (CK_EN ? s : 32'd0)) begin
         n_fail++;
         $display("FAIL overflow end: got hold %0d done %b err %b wc %0d ck %h, expected %0d 1 1 4 %h",
                  h, s_load_done, s_err_overflow, s_word_count, s_checksum, RD, CK_EN ? s : 32'd0);
      end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_run_restart();
      test_gaps();
      test_checksum();
      test_mid_reset();
      test_overflow();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 7, instruction-memory word-address width (capacity 2^ADDR_W words).
REQ-002 Parameter RUN_DELAY, default 4, cycles cpu_rst stays high after the last word is written (legal range 1..255).
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  single-cycle request to begin or restart a program load.
REQ-006 Port in_valid  input  1  upstream word valid.
REQ-007 Port in_data  input  32  upstream instruction word.
REQ-008 Port in_last  input  1  marks the final word of the program; qualified by in_valid.
REQ-009 Port in_ready  output  1  loader accepts a word this cycle.
REQ-010 Port imem_we  output  1  instruction-memory write enable.
REQ-011 Port imem_addr  output  ADDR_W  instruction-memory word address.
REQ-012 Port imem_wdata  output  32  instruction-memory write data.
REQ-013 Port cpu_rst  output  1  active-high reset to the CPU pipeline; drives the CPU rst input.
REQ-014 Port load_done  output  1  program loaded, CPU released.
REQ-015 Port word_count  output  ADDR_W+1  number of words accepted in the current or last load.
REQ-016 Port err_overflow  output  1  sticky: memory filled before in_last arrived.
REQ-017 Port checksum  output  32  running sum of accepted words (see Configuration).

Function
REQ-018 The loader SHALL implement FSM states IDLE, LOAD, HOLD and RUN.
REQ-019 IDLE: in_ready=0, cpu_rst=1; start=1 -> LOAD, address counter, word_count, err_overflow and checksum cleared.
REQ-020 LOAD: in_ready=1; a word is accepted in any cycle with in_valid=1 and in_ready=1.
REQ-021 On acceptance, imem_we=1, imem_addr=current address counter, imem_wdata=in_data in the same cycle (zero latency); counter and word_count increment at the clock edge.
REQ-022 imem_we SHALL be 0 in every cycle without acceptance; imem_addr SHALL show the counter value at all times.
REQ-023 Accepted word with in_last=1 -> HOLD; the hold counter loads RUN_DELAY.
REQ-024 Accepted word at address 2^ADDR_W-1 with in_last=0 -> HOLD with err_overflow set to 1; the counter does not wrap past the top address.
REQ-025 HOLD: in_ready=0, cpu_rst=1; the hold counter decrements each cycle; RUN is entered on the edge where it reaches 0, giving exactly RUN_DELAY cycles in HOLD.
REQ-026 RUN: cpu_rst=0, load_done=1, in_ready=0; start=1 -> LOAD with cpu_rst=1 from the next cycle, and load_done, counters, err_overflow and checksum cleared.
REQ-027 start SHALL be ignored in LOAD and HOLD.
REQ-028 in_ready, cpu_rst and load_done SHALL be decoded from registered state only, with no combinational path from inputs.
REQ-029 in_valid with in_ready=0 SHALL cause no write and no counter change.
REQ-030 word_count SHALL reach 2^ADDR_W on a full-memory load without wrapping.

Reset
REQ-031 When rst=1 at a clock edge, the loader SHALL enter IDLE regardless of state, including mid-LOAD and mid-HOLD.
REQ-032 Reset values: in_ready=0, imem_we=0, imem_addr=0, cpu_rst=1, load_done=0, word_count=0, err_overflow=0, checksum=0.
REQ-033 A word presented during the reset cycle SHALL NOT be written.

Configuration
REQ-034 Macro IMEM_LOADER_CHECKSUM_EN defined: checksum accumulates the modulo-2^32 sum of every accepted in_data, is cleared on start and reset, and holds its value in HOLD and RUN.
REQ-035 Macro IMEM_LOADER_CHECKSUM_EN undefined: checksum SHALL be constant 0 and no accumulator logic is present; all other behaviour is unchanged.

Verification
REQ-036 Reset, then start and three words 0x20010005, 0x20020003, 0x00000000 (last on the third) -> writes to addresses 0..2, word_count=3, cpu_rst high for exactly 4 cycles after the third write, then load_done=1 and cpu_rst=0.
REQ-037 Same load with in_valid toggling every other cycle -> only valid cycles write, addresses contiguous 0..2, no duplicate writes.
REQ-038 ADDR_W=2, five words with no in_last -> four writes to addresses 0..3, err_overflow=1, word_count=4, fifth word not accepted (in_ready=0), then RUN after RUN_DELAY.
REQ-039 rst asserted after the second word of a load -> IDLE next cycle, cpu_rst=1, word_count=0; a later start reloads from address 0.
REQ-040 In RUN, start=1 -> cpu_rst=1 and load_done=0 on the next cycle, second load begins at address 0; start pulsed during LOAD has no effect.
REQ-041 With IMEM_LOADER_CHECKSUM_EN defined, words 0xFFFFFFFF and 0x00000002 -> checksum=0x00000001; undefined -> checksum=0.
